// File: rtl/q_argmax_scanner.sv
// q_argmax_scanner: steps the select of a 16:1 Q-value mux one input per cycle
// and reports the index and value of the largest eligible (masked-in) entry.
// A scan is start -> SCAN (NUM_IN cycles) -> DONE (one-cycle done pulse) -> IDLE.
// Results are cleared when a scan is accepted and then held from done until
// the next accepted start.
module q_argmax_scanner #(
  parameter int DATA_W = 16,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 4,
  parameter bit SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_IN-1:0] mask,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic [DATA_W-1:0] mux_dout,
  output logic              busy,
  output logic              done,
  output logic [SEL_W-1:0]  best_idx,
  output logic [DATA_W-1:0] best_val,
  output logic              none_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_IN - 1);

  state_t              state_r;
  logic [NUM_IN-1:0]   mask_r;
  logic                found_r;
  logic                take_s;
  logic                last_s;

  // Strict greater-than in the configured number format; strictness makes
  // the lowest index win on ties.
  function automatic logic is_greater(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
    if (SIGNED) begin
      return ($signed(a) > $signed(b));
    end else begin
      return (a > b);
    end
  endfunction

  // Decide whether the entry currently on the mux replaces the running best.
  always_comb begin
    take_s = 1'b0;
    last_s = (mux_sel == LAST_SEL);
    if (mask_r[mux_sel] && (!found_r || is_greater(mux_dout, best_val))) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
  end

  // Scan sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      mask_r     <= '0;
      found_r    <= 1'b0;
      mux_sel    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_idx   <= '0;
      best_val   <= '0;
      none_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done    <= 1'b0;
          mux_sel <= '0;
          if (start) begin
            mask_r     <= mask;
            found_r    <= 1'b0;
            best_idx   <= '0;
            best_val   <= '0;
            none_valid <= 1'b0;
            busy       <= 1'b1;
            state_r    <= SCAN;
          end else begin
            busy <= 1'b0;
          end
        end
        SCAN: begin
          if (take_s) begin
            best_val <= mux_dout;
            best_idx <= mux_sel;
            found_r  <= 1'b1;
          end
          if (last_s) begin
            // none_valid must already be correct in the done cycle, so it
            // accounts for the final entry being taken right now.
            none_valid <= ~(found_r | take_s);
            done       <= 1'b1;
            state_r    <= DONE;
          end else begin
            mux_sel <= mux_sel + SEL_W'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          mux_sel <= '0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          mux_sel <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
